// File: rtl/temporal_encoder_pkg.sv
// -----------------------------------------------------------------------------
// temporal_encoder_pkg
//   Shared constants, types and helpers for the temporal (N-gram) encoder.
//
//   Handshake conventions used on both sides of the encoder:
//     - A transfer happens in a cycle where valid && ready are both high.
//     - The producer holds its data stable while valid is high and ready low.
//     - ready may depend combinationally on the downstream ready, but valid
//       never depends on ready.
// -----------------------------------------------------------------------------
package temporal_encoder_pkg;

  // Width of the spatial hypervector produced by the spatial accumulator.
  localparam int SPATIAL_DIMENSION = 2000;

  // The temporal encoder works on the spatial hypervectors directly, so its
  // width is tied to the spatial dimension.
  localparam int TE_DIMENSION = SPATIAL_DIMENSION;

  // Default number of samples bound into one N-gram, and its legal maximum.
  localparam int TE_NGRAM_SIZE  = 3;
  localparam int NGRAM_SIZE_MAX = 8;

  // Encoder state. It is not stored separately; it is decoded from the
  // history fill counter.
  typedef enum logic {
    ST_FILLING = 1'b0,
    ST_FULL    = 1'b1
  } fill_state_e;

  // Width of the fill counter / FillCount_SO output.
  function automatic int fill_cnt_width(input int ngram_size);
    return $clog2(ngram_size) + 1;
  endfunction

  // Source bit index for a rotation by 'shift' toward the higher index:
  // out[idx] = in[(idx - shift) mod dim].
  function automatic int rot_src(input int idx, input int shift, input int dim);
    return ((idx - (shift % dim)) + dim) % dim;
  endfunction

endpackage : temporal_encoder_pkg

// File: rtl/hv_permute.sv
// -----------------------------------------------------------------------------
// hv_permute
//   Pure wiring: rotates a hypervector by SHIFT positions toward the higher
//   index (rho^SHIFT). Bit DIMENSION-1 wraps around to bit 0.
//
//   Ports:
//     i_hv  in  [0:DIMENSION-1]  hypervector to permute
//     o_hv  out [0:DIMENSION-1]  rho^SHIFT(i_hv)
// -----------------------------------------------------------------------------
module hv_permute
  import temporal_encoder_pkg::*;
#(
  parameter int DIMENSION = TE_DIMENSION,
  parameter int SHIFT     = 1
) (
  input  logic [0:DIMENSION-1] i_hv,
  output logic [0:DIMENSION-1] o_hv
);

  for (genvar i = 0; i < DIMENSION; i++) begin : g_bit
    assign o_hv[i] = i_hv[rot_src(i, SHIFT, DIMENSION)];
  end

endmodule : hv_permute

// File: rtl/temporal_encoder.sv
// -----------------------------------------------------------------------------
// temporal_encoder
//   Binds the current spatial hypervector with permuted copies of the previous
//   NGRAM_SIZE-1 samples:
//     NG = In ^ rho(H[0]) ^ rho^2(H[1]) ^ ... ^ rho^(N-1)(H[N-2])
//   H[0] is the most recent previous sample. The N-gram is held in a
//   single-entry output register toward the associative memory.
//
//   Ports:
//     Clk_CI             in   1                 clock
//     Reset_RBI          in   1                 async active-low reset
//     ClearHistory_SI    in   1                 sync flush of history + output
//     ValidIn_SI         in   1                 HypervectorIn_DI is valid
//     ReadyOut_SO        out  1                 input can be accepted
//     HypervectorIn_DI   in   [0:DIMENSION-1]   spatial hypervector
//     ValidOut_SO        out  1                 HypervectorOut_DO is valid
//     ReadyIn_SI         in   1                 downstream takes output
//     HypervectorOut_DO  out  [0:DIMENSION-1]   N-gram hypervector
//     FillCount_SO       out  clog2(N)+1        history entries filled
//
//   NGRAM_SIZE must lie in 1..NGRAM_SIZE_MAX.
// -----------------------------------------------------------------------------
module temporal_encoder
  import temporal_encoder_pkg::*;
#(
  parameter int DIMENSION  = TE_DIMENSION,
  parameter int NGRAM_SIZE = TE_NGRAM_SIZE
) (
  input  logic                                  Clk_CI,
  input  logic                                  Reset_RBI,
  input  logic                                  ClearHistory_SI,
  input  logic                                  ValidIn_SI,
  output logic                                  ReadyOut_SO,
  input  logic [0:DIMENSION-1]                  HypervectorIn_DI,
  output logic                                  ValidOut_SO,
  input  logic                                  ReadyIn_SI,
  output logic [0:DIMENSION-1]                  HypervectorOut_DO,
  output logic [fill_cnt_width(NGRAM_SIZE)-1:0] FillCount_SO
);

  localparam int FCW = fill_cnt_width(NGRAM_SIZE);

  // At least one slot so the arrays stay legal for NGRAM_SIZE == 1; in that
  // case the history is not built and the single tap is tied to zero.
  localparam int HIST_DEPTH = (NGRAM_SIZE > 1) ? NGRAM_SIZE - 1 : 1;

  localparam logic [FCW-1:0] FULL_CNT = FCW'(NGRAM_SIZE - 1);

  logic [FCW-1:0]       r_fill_cnt;
  logic                 r_valid_out;
  logic [0:DIMENSION-1] r_hv_out;

  logic                 w_ready_out;
  logic                 w_accept;
  logic                 w_drain;
  fill_state_e          w_state;
  logic [0:DIMENSION-1] w_ngram;
  logic [0:DIMENSION-1] w_tap [HIST_DEPTH];

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  // The output register can be refilled in the same cycle it drains.
  assign w_ready_out = !r_valid_out || ReadyIn_SI;
  assign w_accept    = ValidIn_SI && w_ready_out;
  assign w_drain     = r_valid_out && ReadyIn_SI;

  assign w_state = (r_fill_cnt == FULL_CNT) ? ST_FULL : ST_FILLING;

  // ---------------------------------------------------------------------------
  // History shift register and permutation taps
  // ---------------------------------------------------------------------------
  if (NGRAM_SIZE > 1) begin : g_hist
    logic [0:DIMENSION-1] r_hist [HIST_DEPTH];

    // NOTE: the history is a small shift register, not a RAM, so every entry
    // is reset; a stale sample would otherwise leak into the first N-grams.
    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
      if (!Reset_RBI) begin
        for (int k = 0; k < HIST_DEPTH; k++) r_hist[k] <= '0;
      end else if (ClearHistory_SI) begin
        for (int k = 0; k < HIST_DEPTH; k++) r_hist[k] <= '0;
      end else if (w_accept) begin
        r_hist[0] <= HypervectorIn_DI;
        for (int k = 1; k < HIST_DEPTH; k++) r_hist[k] <= r_hist[k-1];
      end
    end

    // H[k] is rotated k+1 times before binding.
    for (genvar k = 0; k < HIST_DEPTH; k++) begin : g_tap
      hv_permute #(
        .DIMENSION (DIMENSION),
        .SHIFT     (k + 1)
      ) u_perm (
        .i_hv (r_hist[k]),
        .o_hv (w_tap[k])
      );
    end
  end else begin : g_no_hist
    assign w_tap[0] = '0;
  end

  // ---------------------------------------------------------------------------
  // N-gram binding
  // ---------------------------------------------------------------------------
  // NOTE: w_ngram is assigned first so no path through the block leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    w_ngram = HypervectorIn_DI;
    for (int k = 0; k < NGRAM_SIZE - 1; k++) w_ngram = w_ngram ^ w_tap[k];
  end

  // ---------------------------------------------------------------------------
  // Fill counter
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      r_fill_cnt <= '0;
    end else if (ClearHistory_SI) begin
      r_fill_cnt <= '0;
    end else if (w_accept && (w_state == ST_FILLING)) begin
      r_fill_cnt <= r_fill_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  // An accept while FULL loads a new N-gram; it takes precedence over a
  // same-cycle drain so the register stays valid with the new value. An
  // accept while FILLING with a pending output implies ReadyIn_SI, so that
  // case falls into the drain branch.
  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      r_valid_out <= 1'b0;
      r_hv_out    <= '0;
    end else if (ClearHistory_SI) begin
      r_valid_out <= 1'b0;
      r_hv_out    <= '0;
    end else if (w_accept && (w_state == ST_FULL)) begin
      r_valid_out <= 1'b1;
      r_hv_out    <= w_ngram;
    end else if (w_drain) begin
      r_valid_out <= 1'b0;
    end
  end

  assign ReadyOut_SO       = w_ready_out;
  assign ValidOut_SO       = r_valid_out;
  assign HypervectorOut_DO = r_hv_out;
  assign FillCount_SO      = r_fill_cnt;

endmodule : temporal_encoder

// File: tb/tb_temporal_encoder.sv
// -----------------------------------------------------------------------------
// tb_temporal_encoder
//   Directed bench for temporal_encoder with DIMENSION=8. One instance uses
//   NGRAM_SIZE=3, a second uses NGRAM_SIZE=1. Bit 0 is the leftmost bit of
//   every literal below. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_temporal_encoder;

  localparam int D = 8;

  logic clk;
  logic rst_n;

  // NGRAM_SIZE = 3 instance
  logic         clr;
  logic         v_in;
  logic         rdy_out;
  logic [0:D-1] hv_in;
  logic         v_out;
  logic         rdy_in;
  logic [0:D-1] hv_out;
  logic [2:0]   fill;

  // NGRAM_SIZE = 1 instance
  logic         clr1;
  logic         v_in1;
  logic         rdy_out1;
  logic [0:D-1] hv_in1;
  logic         v_out1;
  logic         rdy_in1;
  logic [0:D-1] hv_out1;
  logic [0:0]   fill1;

  int n_vec  = 0;
  int n_miss = 0;

  temporal_encoder #(
    .DIMENSION  (D),
    .NGRAM_SIZE (3)
  ) u_dut3 (
    .Clk_CI            (clk),
    .Reset_RBI         (rst_n),
    .ClearHistory_SI   (clr),
    .ValidIn_SI        (v_in),
    .ReadyOut_SO       (rdy_out),
    .HypervectorIn_DI  (hv_in),
    .ValidOut_SO       (v_out),
    .ReadyIn_SI        (rdy_in),
    .HypervectorOut_DO (hv_out),
    .FillCount_SO      (fill)
  );

  temporal_encoder #(
    .DIMENSION  (D),
    .NGRAM_SIZE (1)
  ) u_dut1 (
    .Clk_CI            (clk),
    .Reset_RBI         (rst_n),
    .ClearHistory_SI   (clr1),
    .ValidIn_SI        (v_in1),
    .ReadyOut_SO       (rdy_out1),
    .HypervectorIn_DI  (hv_in1),
    .ValidOut_SO       (v_out1),
    .ReadyIn_SI        (rdy_in1),
    .HypervectorOut_DO (hv_out1),
    .FillCount_SO      (fill1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b, expected %b", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    clr    = 1'b0;
    v_in   = 1'b0;
    hv_in  = '0;
    rdy_in = 1'b1;
    clr1   = 1'b0;
    v_in1  = 1'b0;
    hv_in1 = '0;
    rdy_in1 = 1'b1;

    tick();
    tick();
    rst_n = 1'b1;
    #1;

    // --- reset state ---
    check("rst_valid", 64'(v_out), 64'(1'b0));
    check("rst_hv",    64'(hv_out), 64'(8'b00000000));
    check("rst_fill",  64'(fill), 64'(3'd0));
    check("rst_ready", 64'(rdy_out), 64'(1'b1));

    // --- 1: fill with A, B, then C produces the first N-gram ---
    v_in = 1'b1; hv_in = 8'b10000000;  // A
    tick();
    check("A_valid", 64'(v_out), 64'(1'b0));
    check("A_fill",  64'(fill), 64'(3'd1));
    hv_in = 8'b00000001;               // B
    tick();
    check("B_valid", 64'(v_out), 64'(1'b0));
    check("B_fill",  64'(fill), 64'(3'd2));
    hv_in = 8'b11110000;               // C
    tick();
    check("C_valid", 64'(v_out), 64'(1'b1));
    check("C_hv",    64'(hv_out), 64'(8'b01010000));
    check("C_fill",  64'(fill), 64'(3'd2));

    // --- 2: D slides the window: rho(C) ^ rho^2(B) ---
    hv_in = 8'b00000000;               // D
    tick();
    check("D_valid", 64'(v_out), 64'(1'b1));
    check("D_hv",    64'(hv_out), 64'(8'b00111000));

    // --- 3: backpressure for 3 cycles, history must not shift ---
    rdy_in = 1'b0;
    hv_in  = 8'b11001100;              // E
    #1;
    check("bp_ready0", 64'(rdy_out), 64'(1'b0));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_ready",  64'(rdy_out), 64'(1'b0));
      check("bp_valid",  64'(v_out), 64'(1'b1));
      check("bp_hv",     64'(hv_out), 64'(8'b00111000));
    end
    rdy_in = 1'b1;
    #1;
    check("rel_ready", 64'(rdy_out), 64'(1'b1));
    tick();
    // E ^ rho(D) ^ rho^2(C) = 11001100 ^ 00000000 ^ 00111100
    check("E_valid", 64'(v_out), 64'(1'b1));
    check("E_hv",    64'(hv_out), 64'(8'b11110000));

    // --- 4: clear with a pending output and a same-cycle input ---
    rdy_in = 1'b0;
    clr    = 1'b1;
    hv_in  = 8'b10101010;              // dropped
    tick();
    check("clr_valid", 64'(v_out), 64'(1'b0));
    check("clr_fill",  64'(fill), 64'(3'd0));
    check("clr_hv",    64'(hv_out), 64'(8'b00000000));
    clr    = 1'b0;
    rdy_in = 1'b1;
    hv_in  = 8'b10000000;              // G
    tick();
    check("G_valid", 64'(v_out), 64'(1'b0));
    check("G_fill",  64'(fill), 64'(3'd1));
    hv_in  = 8'b00000010;              // H
    tick();
    check("H_valid", 64'(v_out), 64'(1'b0));
    check("H_fill",  64'(fill), 64'(3'd2));
    hv_in  = 8'b11111111;              // I
    tick();
    // I ^ rho(H) ^ rho^2(G) = 11111111 ^ 00000001 ^ 00100000
    check("I_valid", 64'(v_out), 64'(1'b1));
    check("I_hv",    64'(hv_out), 64'(8'b11011110));

    // --- 5: async reset mid-cycle while an output is valid ---
    v_in = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(v_out), 64'(1'b0));
    check("arst_hv",    64'(hv_out), 64'(8'b00000000));
    check("arst_fill",  64'(fill), 64'(3'd0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // --- 6: NGRAM_SIZE=1, pass-through with latency 1 at full rate ---
    check("n1_ready0", 64'(rdy_out1), 64'(1'b1));
    v_in1  = 1'b1;
    hv_in1 = 8'b10110010;
    tick();
    check("n1_valid_a", 64'(v_out1), 64'(1'b1));
    check("n1_hv_a",    64'(hv_out1), 64'(8'b10110010));
    check("n1_fill_a",  64'(fill1), 64'(1'b0));
    hv_in1 = 8'b01010101;
    #1;
    check("n1_ready_b", 64'(rdy_out1), 64'(1'b1));
    tick();
    check("n1_valid_b", 64'(v_out1), 64'(1'b1));
    check("n1_hv_b",    64'(hv_out1), 64'(8'b01010101));
    hv_in1 = 8'b11100001;
    tick();
    check("n1_hv_c",    64'(hv_out1), 64'(8'b11100001));
    check("n1_fill_c",  64'(fill1), 64'(1'b0));
    v_in1 = 1'b0;
    tick();
    check("n1_drain",   64'(v_out1), 64'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_temporal_encoder
